// File: rtl/alu_pkg.sv
// Shared constants for the registered ALU: default width and bit positions of the
// operand-control and operation-select words.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam int IN_SEL_W   = 3;
  localparam int IN_CLR     = 0;
  localparam int IN_LOAD    = 1;
  localparam int IN_PERSIST = 2;

  localparam int OP_COUNT = 6;
  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_XOR   = 4;
  localparam int OP_NOT   = 5;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU operation select; zero latency, no flow control.
// The lowest set bit of out_sel wins; an all-zero select yields zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [OP_COUNT-1:0] out_sel,
  output logic [WIDTH-1:0]    result
);

  always_comb begin
    result = '0;
    if (out_sel[OP_ADD])      result = a + b;
    else if (out_sel[OP_SUB]) result = a - b;
    else if (out_sel[OP_AND]) result = a & b;
    else if (out_sel[OP_OR])  result = a | b;
    else if (out_sel[OP_XOR]) result = a ^ b;
    else if (out_sel[OP_NOT]) result = ~a;
  end

endmodule

// File: rtl/alu_main.sv
// Registered ALU top: operand registers feed alu_core, result is registered every edge.
// Latency: operands 2 cycles to out, out_sel 1 cycle; no backpressure, accepts every cycle.
module alu_main
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IN_SEL_W-1:0] in_sel,
  input  logic [WIDTH-1:0]    num1,
  input  logic [WIDTH-1:0]    num2,
  input  logic [OP_COUNT-1:0] out_sel,
  output logic [WIDTH-1:0]    out
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result;

  // Clear outranks load; persist and the idle code both hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (in_sel[IN_CLR]) begin
      a_q <= '0;
      b_q <= '0;
    end else if (in_sel[IN_LOAD]) begin
      a_q <= num1;
      b_q <= num2;
    end else if (in_sel[IN_PERSIST]) begin
      a_q <= a_q;
      b_q <= b_q;
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (a_q),
    .b      (b_q),
    .out_sel(out_sel),
    .result (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out <= '0;
    else        out <= result;
  end

endmodule

// File: tb/tb_alu_main.sv
// Directed bench for alu_main: a cycle model checked every negedge plus literal pins.
module tb_alu_main;

  logic       clk;
  logic       rst_n;
  logic [2:0] in_sel;
  logic [7:0] num1;
  logic [7:0] num2;
  logic [5:0] out_sel;
  logic [7:0] out;

  int total = 0;
  int bad   = 0;

  alu_main #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_sel (in_sel),
    .num1   (num1),
    .num2   (num2),
    .out_sel(out_sel),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: what the result should be for a given operand pair and select word.
  function automatic int model_op(input int a, input int b, input logic [5:0] sel);
    int k;
    k = -1;
    for (int i = 5; i >= 0; i--) if (sel[i]) k = i;
    case (k)
      0:       return (a + b) % 256;
      1:       return (a - b + 256) % 256;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      5:       return 255 - a;
      default: return 0;
    endcase
  endfunction

  int m_a = 0;
  int m_b = 0;
  int m_out = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_out = 0;
    end else begin
      m_out = model_op(m_a, m_b, out_sel);
      if (in_sel[0]) begin
        m_a = 0; m_b = 0;
      end else if (in_sel[1]) begin
        m_a = int'(num1); m_b = int'(num2);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) check("model", out, 8'(m_out));
  end

  // Drive one cycle of inputs, then return just after the edge that consumed them.
  task automatic apply(input logic [2:0] s, input logic [7:0] n1, input logic [7:0] n2,
                       input logic [5:0] o);
    in_sel = s; num1 = n1; num2 = n2; out_sel = o;
    @(posedge clk);
    #2;
  endtask

  localparam logic [5:0] ADD = 6'b000001;
  localparam logic [5:0] SUB = 6'b000010;
  localparam logic [5:0] AND_ = 6'b000100;
  localparam logic [5:0] OR_ = 6'b001000;
  localparam logic [5:0] XOR_ = 6'b010000;
  localparam logic [5:0] NOT_ = 6'b100000;

  initial begin
    rst_n = 1'b0; in_sel = 3'b000; num1 = 8'h00; num2 = 8'h00; out_sel = ADD;
    #1;
    check("reset_out", out, 8'h00);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    apply(3'b000, 8'h00, 8'h00, ADD);  check("post_reset_add", out, 8'h00);

    apply(3'b010, 8'h57, 8'h1A, ADD);  check("load_edge_old", out, 8'h00);
    apply(3'b100, 8'hAA, 8'hBB, ADD);  check("load_add", out, 8'h71);
    apply(3'b100, 8'hCC, 8'hDD, ADD);  check("persist_hold", out, 8'h71);

    apply(3'b100, 8'h01, 8'h02, SUB);  check("op_sub", out, 8'h3D);
    apply(3'b100, 8'h03, 8'h04, AND_); check("op_and", out, 8'h12);
    apply(3'b100, 8'h05, 8'h06, OR_);  check("op_or",  out, 8'h5F);
    apply(3'b100, 8'h07, 8'h08, XOR_); check("op_xor", out, 8'h4D);
    apply(3'b100, 8'h09, 8'h0A, NOT_); check("op_not", out, 8'hA8);

    // New operands and new select on the same edge: old operands, new op.
    apply(3'b010, 8'hFF, 8'h02, ADD);  check("load_same_cycle", out, 8'h71);
    apply(3'b100, 8'h00, 8'h00, ADD);  check("wrap_add", out, 8'h01);
    apply(3'b010, 8'h00, 8'h01, SUB);  check("old_ops_sub", out, 8'hFD);
    apply(3'b100, 8'h00, 8'h00, SUB);  check("wrap_sub", out, 8'hFF);

    apply(3'b010, 8'h57, 8'h1A, ADD);
    apply(3'b000, 8'h00, 8'h00, ADD);  check("idle_hold", out, 8'h71);
    apply(3'b011, 8'h33, 8'h44, ADD);  check("clr_load_edge", out, 8'h71);
    apply(3'b000, 8'h00, 8'h00, ADD);  check("clr_beats_load", out, 8'h00);

    apply(3'b010, 8'h57, 8'h1A, ADD);
    apply(3'b100, 8'h00, 8'h00, 6'b000110); check("prio_sub", out, 8'h3D);
    apply(3'b100, 8'h00, 8'h00, 6'b110000); check("prio_xor", out, 8'h4D);
    apply(3'b100, 8'h00, 8'h00, 6'b000000); check("sel_zero", out, 8'h00);

    apply(3'b001, 8'h11, 8'h22, OR_);  check("clear_edge", out, 8'h5F);
    apply(3'b100, 8'h11, 8'h22, OR_);  check("clear_or", out, 8'h00);

    // Mid-cycle reset after a load must wipe operands as well as out.
    apply(3'b010, 8'h57, 8'h1A, ADD);
    apply(3'b100, 8'h00, 8'h00, ADD);  check("pre_reset", out, 8'h71);
    #1 rst_n = 1'b0;
    #1 check("async_reset", out, 8'h00);
    @(posedge clk); #1;
    check("reset_held", out, 8'h00);
    #1 rst_n = 1'b1;
    apply(3'b100, 8'h00, 8'h00, NOT_); check("reset_ops_cleared", out, 8'hFF);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
